trig_match_gen: RTL and testbench

Parametrised LCT/L1A match generator for the CFEB trigger path: delays the LCT by a run-time programmable L1A latency and matches it against L1A_MATCH in a programmable window. It produces MATCHR/NO_MATCH per LCT and GMATCH/DAV/MISS_MATCH per L1A. Readout overlap is tracked with a parametrised occupancy limit. Saturating event counters are provided for monitoring. It sits in blkscam between the LCT input delay and the readout controller.

---
 rtl/trig_match_gen.sv | 213 +++++++++++++++++++++
 tb/tb_trig_match_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_match_gen.sv
// trig_match_gen
//   Delays each LCT by a programmable latency, then matches it against
//   L1A_MATCH inside a +/-H window. Produces one decision per LCT
//   (MATCHR / NO_MATCH) and one per L1A_MATCH (GMATCH+DAV or MISS_MATCH).
//   Readout occupancy is limited to MAX_OVR grants, each held for
//   OVR_DEPTH clocks. Saturating counters track MATCHR, NO_MATCH and
//   MISS_MATCH pulses.
//
// Ports
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   LCT        LCT pulse from the input delay
//   L1A        level-1 accept
//   L1A_MATCH  L1A with CFEB match
//   TRG_DCD    bypass mode: decisions come straight from L1A/L1A_MATCH
//   LAT        LCT latency in clocks (0 acts as 1, clamped to MAX_LAT)
//   H          window half-width (clamped to MAX_H)
//   CNT_CLR    synchronous counter clear
//   MATCHR, NO_MATCH, GMATCH, DAV, MISS_MATCH  one-clock registered pulses
//   N_MATCH, N_NOMATCH, N_MISS                 saturating event counts
//   OCC        current readout occupancy
module trig_match_gen #(
  parameter int MAX_LAT   = 512,
  parameter int LAT_W     = 9,
  parameter int MAX_H     = 3,
  parameter int OVR_DEPTH = 16,
  parameter int MAX_OVR   = 2,
  parameter int CNT_W     = 16,
  parameter int TMR       = 0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         LCT,
  input  logic                         L1A,
  input  logic                         L1A_MATCH,
  input  logic                         TRG_DCD,
  input  logic [LAT_W-1:0]             LAT,
  input  logic [1:0]                   H,
  input  logic                         CNT_CLR,
  output logic                         MATCHR,
  output logic                         NO_MATCH,
  output logic                         GMATCH,
  output logic                         DAV,
  output logic                         MISS_MATCH,
  output logic [CNT_W-1:0]             N_MATCH,
  output logic [CNT_W-1:0]             N_NOMATCH,
  output logic [CNT_W-1:0]             N_MISS,
  output logic [$clog2(MAX_OVR+1)-1:0] OCC
);

  localparam int AW    = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int FW    = $clog2(MAX_LAT + 1);
  localparam int HD    = 2 * MAX_H;           // registered history depth
  localparam int OW    = $clog2(MAX_OVR + 1);
  localparam int NCOPY = (TMR != 0) ? 3 : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clamped run-time settings, widened so the range checks stay honest.
  logic [31:0] lat_ext, lat_eff, h_ext, h_eff;

  always_comb begin
    lat_ext = 32'(LAT);
    h_ext   = {30'd0, H};
    if (lat_ext == 32'd0)
      lat_eff = 32'd1;
    else if (lat_ext > 32'(MAX_LAT))
      lat_eff = 32'(MAX_LAT);
    else
      lat_eff = lat_ext;
    h_eff = (h_ext > 32'(MAX_H)) ? 32'(MAX_H) : h_ext;
  end

  // ---------------- latency buffer ----------------
  logic          ram [MAX_LAT];
  logic [AW-1:0] wp_reg;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_sum;
  logic          ram_q_reg;
  logic          lct_prev_reg;
  logic [FW-1:0] fill_reg;
  logic          lct_d;

  // The read is registered, so address the entry needed one clock ahead:
  // (wp - LAT + 1) mod MAX_LAT.
  always_comb begin
    rd_sum  = 32'(wp_reg) + 32'(MAX_LAT) + 32'd1 - lat_eff;
    rd_addr = (rd_sum >= 32'(MAX_LAT)) ? AW'(rd_sum - 32'(MAX_LAT)) : AW'(rd_sum);
  end

  always_ff @(posedge CLK) begin
    ram[wp_reg] <= LCT;
    ram_q_reg   <= ram[rd_addr];
  end

  // LAT=1 would read the slot being written this clock, so take it from
  // a plain one-clock delay instead. The fill gate hides pre-reset data.
  assign lct_d = (32'(fill_reg) >= lat_eff) &
                 ((lat_eff == 32'd1) ? lct_prev_reg : ram_q_reg);

  // ---------------- history windows ----------------
  // win[k] is the value k clocks ago; win[0] is the current clock.
  logic [HD-1:0] lh_reg, mh_reg;
  logic [HD:0]   lwin, mwin, win_mask, mid_mask;

  assign lwin = {lh_reg, lct_d};
  assign mwin = {mh_reg, L1A_MATCH};

  genvar gi;
  generate
    for (gi = 0; gi <= HD; gi++) begin : g_mask
      assign win_mask[gi] = (32'(gi) <= (h_eff << 1));
      assign mid_mask[gi] = (32'(gi) == h_eff);
    end
  endgenerate

  // ---------------- decisions and overlap ----------------
  logic             pyes, pno, prematch, grant, pmiss, rel;
  logic [OVR_DEPTH-1:0] gr_sr_reg;
  logic [OVR_DEPTH:0]   grw;
  logic [OW-1:0]    occ_q, occ_eff, occ_next;
  logic [OW-1:0]    occ_copy_reg [NCOPY];

  assign grw = {gr_sr_reg, grant};
  assign rel = grw[OVR_DEPTH];     // grant issued OVR_DEPTH clocks ago

  always_comb begin
    pyes     = 1'b0;
    pno      = 1'b0;
    prematch = 1'b0;
    if (TRG_DCD) begin
      pyes     = L1A_MATCH;
      pno      = L1A & ~L1A_MATCH;
      prematch = L1A_MATCH;
    end else begin
      pyes     = (|(lwin & mid_mask)) &  (|(mwin & win_mask));
      pno      = (|(lwin & mid_mask)) & ~(|(mwin & win_mask));
      prematch = (|(mwin & mid_mask)) &  (|(lwin & win_mask));
    end
  end

  always_comb begin
    occ_eff  = occ_q - OW'(rel);
    grant    = prematch && (32'(occ_eff) < 32'(MAX_OVR));
    pmiss    = prematch && !grant;
    occ_next = occ_eff + OW'(grant);
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NCOPY; i++) begin
      if (RST) occ_copy_reg[i] <= '0;
      else     occ_copy_reg[i] <= occ_next;
    end
  end

  generate
    if (NCOPY == 3) begin : g_vote
      assign occ_q = (occ_copy_reg[0] & occ_copy_reg[1]) |
                     (occ_copy_reg[0] & occ_copy_reg[2]) |
                     (occ_copy_reg[1] & occ_copy_reg[2]);
    end else begin : g_single
      assign occ_q = occ_copy_reg[0];
    end
  endgenerate

  assign OCC = occ_q;

  // ---------------- pipeline state and outputs ----------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      wp_reg       <= '0;
      fill_reg     <= '0;
      lct_prev_reg <= 1'b0;
      lh_reg       <= '0;
      mh_reg       <= '0;
      gr_sr_reg    <= '0;
      MATCHR       <= 1'b0;
      NO_MATCH     <= 1'b0;
      GMATCH       <= 1'b0;
      DAV          <= 1'b0;
      MISS_MATCH   <= 1'b0;
    end else begin
      wp_reg       <= (wp_reg == AW'(MAX_LAT - 1)) ? '0 : wp_reg + AW'(1);
      if (32'(fill_reg) < 32'(MAX_LAT))
        fill_reg   <= fill_reg + FW'(1);
      lct_prev_reg <= LCT;
      lh_reg       <= lwin[HD-1:0];
      mh_reg       <= mwin[HD-1:0];
      gr_sr_reg    <= grw[OVR_DEPTH-1:0];
      MATCHR       <= pyes;
      NO_MATCH     <= pno;
      GMATCH       <= grant;
      DAV          <= grant;
      MISS_MATCH   <= pmiss;
    end
  end

  // ---------------- saturating counters ----------------
  always_ff @(posedge CLK) begin
    if (RST || CNT_CLR) begin
      N_MATCH   <= '0;
      N_NOMATCH <= '0;
      N_MISS    <= '0;
    end else begin
      if (MATCHR && N_MATCH != CNT_MAX)
        N_MATCH <= N_MATCH + CNT_W'(1);
      if (NO_MATCH && N_NOMATCH != CNT_MAX)
        N_NOMATCH <= N_NOMATCH + CNT_W'(1);
      if (MISS_MATCH && N_MISS != CNT_MAX)
        N_MISS <= N_MISS + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_trig_match_gen.sv
// Testbench for trig_match_gen: directed scenarios plus randomized phases,
// checked every cycle against a cycle-indexed behavioural model.
module tb_trig_match_gen;

  localparam int MAX_LAT   = 512;
  localparam int LAT_W     = 9;
  localparam int MAX_H     = 3;
  localparam int OVR_DEPTH = 16;
  localparam int MAX_OVR   = 2;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int NCYC      = 12000;
  localparam int NST       = 1024;

  logic             CLK = 1'b0;
  logic             RST = 1'b0, LCT = 1'b0, L1A = 1'b0, L1A_MATCH = 1'b0;
  logic             TRG_DCD = 1'b0, CNT_CLR = 1'b0;
  logic [LAT_W-1:0] LAT = 9'd1;
  logic [1:0]       H = 2'd0;
  logic             MATCHR, NO_MATCH, GMATCH, DAV, MISS_MATCH;
  logic [CNT_W-1:0] N_MATCH, N_NOMATCH, N_MISS;
  logic [1:0]       OCC;

  trig_match_gen #(
    .MAX_LAT(MAX_LAT), .LAT_W(LAT_W), .MAX_H(MAX_H), .OVR_DEPTH(OVR_DEPTH),
    .MAX_OVR(MAX_OVR), .CNT_W(CNT_W), .TMR(0)
  ) dut (
    .CLK(CLK), .RST(RST), .LCT(LCT), .L1A(L1A), .L1A_MATCH(L1A_MATCH),
    .TRG_DCD(TRG_DCD), .LAT(LAT), .H(H), .CNT_CLR(CNT_CLR),
    .MATCHR(MATCHR), .NO_MATCH(NO_MATCH), .GMATCH(GMATCH), .DAV(DAV),
    .MISS_MATCH(MISS_MATCH), .N_MATCH(N_MATCH), .N_NOMATCH(N_NOMATCH),
    .N_MISS(N_MISS), .OCC(OCC)
  );

  always #5 CLK = ~CLK;

  // Stimulus history and expected pulses, indexed by absolute cycle.
  bit lct_a [NCYC], l1a_a [NCYC], l1am_a [NCYC], rst_a [NCYC], clr_a [NCYC];
  bit exp_m [NCYC], exp_n [NCYC], exp_g [NCYC], exp_x [NCYC], grant_a [NCYC];
  int obs_m [NCYC], obs_n [NCYC], obs_d [NCYC], obs_x [NCYC];
  int obs_occ [NCYC], obs_nm [NCYC], obs_nn [NCYC];

  // Per-phase stimulus, indexed by cycle relative to the phase reset.
  bit st_lct [NST], st_l1a [NST], st_l1am [NST], st_rst [NST], st_clr [NST];

  int cyc = 0, rcyc = -1, base = 0;
  int checks = 0, errors = 0;
  bit started = 1'b0;
  int cur_lat = 1, cur_h = 0;
  bit cur_trg = 1'b0;
  int nxt_lat_drv = 1, nxt_h = 0;
  bit nxt_trg = 1'b0;
  int grant_q [$];

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Delayed LCT as the matcher should see it: LCT from LAT clocks ago,
  // but only if that LCT arrived after the latest reset.
  function automatic bit lctd(input int t);
    if (t - cur_lat <= rcyc || t - cur_lat < 0) return 1'b0;
    return lct_a[t - cur_lat];
  endfunction

  function automatic bit l1amv(input int t);
    if (t <= rcyc || t < 0) return 1'b0;
    return l1am_a[t];
  endfunction

  // Decisions made in cycle e appear on the outputs in cycle e+1.
  task automatic model_decide(input int e);
    bit pyes = 0, pno = 0, pre = 0, gr = 0, ms = 0;
    bit anym = 0, anyl = 0;
    if (rst_a[e]) begin
      grant_q.delete();
    end else if (cur_trg) begin
      pyes = l1am_a[e];
      pno  = l1a_a[e] && !l1am_a[e];
      pre  = l1am_a[e];
    end else begin
      for (int k = e - 2 * cur_h; k <= e; k++) begin
        anym |= l1amv(k);
        anyl |= lctd(k);
      end
      pyes = lctd(e - cur_h) && anym;
      pno  = lctd(e - cur_h) && !anym;
      pre  = l1amv(e - cur_h) && anyl;
    end
    // Grants older than OVR_DEPTH clocks no longer occupy readout.
    while (grant_q.size() > 0 && grant_q[0] <= e - OVR_DEPTH)
      void'(grant_q.pop_front());
    gr = pre && (grant_q.size() < MAX_OVR);
    ms = pre && !gr;
    if (gr) grant_q.push_back(e);
    grant_a[e] = gr;
    if (e + 1 < NCYC) begin
      exp_m[e+1] = pyes;
      exp_n[e+1] = pno;
      exp_g[e+1] = gr;
      exp_x[e+1] = ms;
    end
  endtask

  // Occupancy seen in cycle c: grants in the last OVR_DEPTH cycles since reset.
  function automatic int model_occ(input int c);
    int n = 0;
    for (int g = c - 1; g >= c - OVR_DEPTH && g >= 0; g--) begin
      if (rst_a[g]) break;
      n += int'(grant_a[g]);
    end
    return n;
  endfunction

  // Counter value in cycle c: pulses since the last clear, saturated.
  function automatic int model_cnt(input int c, input int which);
    int n = 0;
    for (int p = c - 1; p >= 0; p--) begin
      if (rst_a[p] || clr_a[p]) break;
      if (which == 0) n += int'(exp_m[p]);
      else if (which == 1) n += int'(exp_n[p]);
      else n += int'(exp_x[p]);
    end
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  task automatic step(input bit lct, input bit l1a, input bit l1am,
                      input bit rst, input bit clr);
    @(negedge CLK);
    if (started) begin
      check_val("matchr",     int'(MATCHR),     int'(exp_m[cyc]));
      check_val("no_match",   int'(NO_MATCH),   int'(exp_n[cyc]));
      check_val("gmatch",     int'(GMATCH),     int'(exp_g[cyc]));
      check_val("dav",        int'(DAV),        int'(exp_g[cyc]));
      check_val("miss_match", int'(MISS_MATCH), int'(exp_x[cyc]));
      check_val("occ",        int'(OCC),        model_occ(cyc));
      check_val("n_match",    int'(N_MATCH),    model_cnt(cyc, 0));
      check_val("n_nomatch",  int'(N_NOMATCH),  model_cnt(cyc, 1));
      check_val("n_miss",     int'(N_MISS),     model_cnt(cyc, 2));
      obs_m[cyc]   = int'(MATCHR);
      obs_n[cyc]   = int'(NO_MATCH);
      obs_d[cyc]   = int'(DAV);
      obs_x[cyc]   = int'(MISS_MATCH);
      obs_occ[cyc] = int'(OCC);
      obs_nm[cyc]  = int'(N_MATCH);
      obs_nn[cyc]  = int'(N_NOMATCH);
    end
    if (rst) begin
      // Settings change only together with a reset.
      LAT     = LAT_W'(nxt_lat_drv);
      H       = 2'(nxt_h);
      TRG_DCD = nxt_trg;
      cur_lat = (nxt_lat_drv == 0) ? 1 : ((nxt_lat_drv > MAX_LAT) ? MAX_LAT : nxt_lat_drv);
      cur_h   = (nxt_h > MAX_H) ? MAX_H : nxt_h;
      cur_trg = nxt_trg;
    end
    LCT = lct; L1A = l1a; L1A_MATCH = l1am; RST = rst; CNT_CLR = clr;
    lct_a[cyc] = lct; l1a_a[cyc] = l1a; l1am_a[cyc] = l1am;
    rst_a[cyc] = rst; clr_a[cyc] = clr;
    if (rst) begin
      rcyc = cyc;
      started = 1'b1;
    end
    model_decide(cyc);
    cyc++;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NST; i++) begin
      st_lct[i] = 0; st_l1a[i] = 0; st_l1am[i] = 0; st_rst[i] = 0; st_clr[i] = 0;
    end
  endtask

  task automatic run_phase(input string name, input int lat, input int h,
                           input bit trg, input int len);
    int c0 = checks;
    nxt_lat_drv = lat; nxt_h = h; nxt_trg = trg;
    step(0, 0, 0, 1, 0);
    base = cyc;
    for (int i = 0; i < len; i++)
      step(st_lct[i], st_l1a[i], st_l1am[i], st_rst[i], st_clr[i]);
    $display("phase %s lat=%0d h=%0d trg=%0d cycles=%0d checks=%0d",
             name, lat, h, trg, len, checks - c0);
  endtask

  initial begin
    // Basic window match.
    clear_stim(); st_lct[10] = 1; st_l1am[111] = 1;
    run_phase("basic", 100, 1, 0, 130);
    check_val("basic_matchr112", obs_m[base+112], 1);
    check_val("basic_dav113",    obs_d[base+113], 1);
    check_val("basic_nmatch",    obs_nm[base+120], 1);

    // Window edges, H=2.
    clear_stim(); st_lct[10] = 1; st_l1am[108] = 1;
    run_phase("edge108", 100, 2, 0, 130);
    check_val("edge108_matchr", obs_m[base+113], 1);
    clear_stim(); st_lct[10] = 1; st_l1am[107] = 1;
    run_phase("edge107", 100, 2, 0, 130);
    check_val("edge107_nomatch", obs_n[base+113], 1);
    clear_stim(); st_lct[10] = 1; st_l1am[113] = 1;
    run_phase("edge113", 100, 2, 0, 130);
    check_val("edge113_nomatch", obs_n[base+113], 1);

    // Window edges, H=0.
    clear_stim(); st_lct[10] = 1; st_l1am[110] = 1;
    run_phase("h0_110", 100, 0, 0, 125);
    check_val("h0_110_matchr", obs_m[base+111], 1);
    clear_stim(); st_lct[10] = 1; st_l1am[109] = 1;
    run_phase("h0_109", 100, 0, 0, 125);
    check_val("h0_109_nomatch", obs_n[base+111], 1);

    // Overlap limit in bypass mode.
    clear_stim(); st_l1am[0] = 1; st_l1am[1] = 1; st_l1am[2] = 1; st_l1am[16] = 1;
    run_phase("overlap", 1, 0, 1, 40);
    check_val("ovr_dav1",  obs_d[base+1], 1);
    check_val("ovr_dav2",  obs_d[base+2], 1);
    check_val("ovr_miss3", obs_x[base+3], 1);
    check_val("ovr_occ3",  obs_occ[base+3], 2);
    check_val("ovr_dav17", obs_d[base+17], 1);

    // Simultaneous release and grant.
    clear_stim(); st_l1am[0] = 1; st_l1am[1] = 1; st_l1am[16] = 1; st_l1am[17] = 1;
    run_phase("simul", 1, 0, 1, 40);
    check_val("sim_occ17", obs_occ[base+17], 2);
    check_val("sim_occ18", obs_occ[base+18], 2);
    check_val("sim_dav18", obs_d[base+18], 1);

    // Reset and fill: LCT every cycle, reset mid-phase.
    clear_stim();
    for (int i = 0; i < 130; i++) st_lct[i] = 1;
    st_rst[50] = 1;
    run_phase("fill", 40, 1, 0, 130);
    begin
      int early = 0;
      for (int c = base + 51; c <= base + 92; c++) early += obs_m[c] + obs_n[c];
      check_val("fill_quiet", early, 0);
    end
    check_val("fill_first93",  obs_n[base+93], 1);
    check_val("fill_cnt51",    obs_nn[base+51], 0);
    check_val("fill_occ51",    obs_occ[base+51], 0);

    // Saturation and coincident clear.
    clear_stim();
    for (int i = 0; i < 20; i++) st_l1a[i] = 1;
    st_l1a[25] = 1; st_clr[26] = 1;
    run_phase("saturate", 1, 0, 1, 32);
    check_val("sat_15",   obs_nn[base+22], CNT_MAX);
    check_val("sat_clr0", obs_nn[base+27], 0);

    // Randomized phases.
    for (int p = 0; p < 6; p++) begin
      int lat, h, len;
      bit trg;
      lat = (p == 0) ? 0 : (p == 1) ? 511 : (p == 2) ? 1 : int'($urandom_range(2, 120));
      h   = int'($urandom_range(0, 3));
      trg = (p == 5) || ($urandom_range(0, 3) == 0);
      len = ((lat == 0) ? 1 : lat) + 150;
      clear_stim();
      for (int i = 0; i < len; i++) begin
        st_lct[i]  = ($urandom_range(0, 7) == 0);
        st_l1am[i] = ($urandom_range(0, 5) == 0);
        st_l1a[i]  = st_l1am[i] || ($urandom_range(0, 4) == 0);
        st_clr[i]  = ($urandom_range(0, 63) == 0);
      end
      run_phase("random", lat, h, trg, len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
